instruction_memory: RTL and testbench



---
 rtl/instruction_memory.sv | 108 ++++++++++
 tb/tb_instruction_memory.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory.sv
// Word-addressed instruction memory with a fixed-latency read pipeline, flush and a load port.
// Optional accepted-fetch counter: define INSTRUCTION_MEMORY_FETCH_COUNT_EN.
module instruction_memory #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_3000,
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_valid,
    input  logic [29:0] fetch_addr,
    output logic        fetch_ready,
    input  logic        flush,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic        inst_fault,
    input  logic        load_enable,
    input  logic [29:0] load_addr,
    input  logic [31:0] load_data
`ifdef INSTRUCTION_MEMORY_FETCH_COUNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
    localparam logic [29:0] BaseWord = BASE_ADDR[31:2];
    localparam logic [29:0] DepthW   = 30'(DEPTH_WORDS);

    logic [29:0] fetch_index;
    logic [29:0] load_index;
    logic        fetch_in_range;
    logic        load_in_range;
    logic        fetch_accept;
    logic [31:0] stage0_data_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic [READ_LATENCY-1:0] valid_q;
    logic [READ_LATENCY-1:0] fault_q;
    logic [31:0]             data_q [READ_LATENCY];

    // Addresses below the base wrap to huge indices, so the explicit >= test keeps them out.
    always_comb begin
        fetch_index    = fetch_addr - BaseWord;
        load_index     = load_addr - BaseWord;
        fetch_in_range = (fetch_addr >= BaseWord) && (fetch_index < DepthW);
        load_in_range  = (load_addr >= BaseWord) && (load_index < DepthW);
        fetch_ready    = !load_enable;
        fetch_accept   = fetch_valid && fetch_ready;
    end

    always_comb begin
        stage0_data_d = '0;
        if (fetch_accept && fetch_in_range) begin
            stage0_data_d = mem[fetch_index[IdxW-1:0]];
        end
    end

    // Loads ignore reset: reset only touches pipeline state.
    always_ff @(posedge clock) begin
        if (load_enable && load_in_range) begin
            mem[load_index[IdxW-1:0]] <= load_data;
        end
    end

    // A fetch accepted alongside flush is the new target and is not squashed.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= fetch_accept;
            for (int i = 1; i < READ_LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1] && !flush;
            end
        end
    end

    always_ff @(posedge clock) begin
        fault_q[0] <= fetch_accept && !fetch_in_range;
        data_q[0]  <= stage0_data_d;
        for (int i = 1; i < READ_LATENCY; i++) begin
            fault_q[i] <= fault_q[i-1];
            data_q[i]  <= data_q[i-1];
        end
    end

    always_comb begin
        inst_valid = valid_q[READ_LATENCY-1];
        inst_fault = inst_valid && fault_q[READ_LATENCY-1];
        inst_data  = inst_valid ? data_q[READ_LATENCY-1] : 32'h0000_0000;
    end

`ifdef INSTRUCTION_MEMORY_FETCH_COUNT_EN
    logic [31:0] fetch_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count_q <= '0;
        end else if (fetch_accept) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_instruction_memory.sv
// Drives three instruction_memory instances (latency 1..3) with shared stimulus and checks each
// against a history-based reference model.
module tb_instruction_memory;

    localparam int          Depth   = 16;
    localparam int          NumDut  = 3;
    localparam int          MaxCyc  = 1024;
    localparam logic [31:0] Base    = 32'h0000_3000;
    localparam longint      BaseW   = 32'h0000_3000 / 4;

    logic        clock;
    logic        reset;
    logic        fetch_valid;
    logic [29:0] fetch_addr;
    logic        flush;
    logic        load_enable;
    logic [29:0] load_addr;
    logic [31:0] load_data;

    logic        ready  [NumDut];
    logic        ivalid [NumDut];
    logic [31:0] idata  [NumDut];
    logic        ifault [NumDut];
    logic [31:0] cnt    [NumDut];

    for (genvar g = 0; g < NumDut; g++) begin : g_dut
        instruction_memory #(
            .BASE_ADDR   (Base),
            .DEPTH_WORDS (Depth),
            .READ_LATENCY(g + 1)
        ) u_dut (
            .clock      (clock),
            .reset      (reset),
            .fetch_valid(fetch_valid),
            .fetch_addr (fetch_addr),
            .fetch_ready(ready[g]),
            .flush      (flush),
            .inst_valid (ivalid[g]),
            .inst_data  (idata[g]),
            .inst_fault (ifault[g]),
            .load_enable(load_enable),
            .load_addr  (load_addr),
            .load_data  (load_data)
`ifdef INSTRUCTION_MEMORY_FETCH_COUNT_EN
            ,
            .fetch_count(cnt[g])
`endif
        );
`ifndef INSTRUCTION_MEMORY_FETCH_COUNT_EN
        assign cnt[g] = '0;
`endif
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int tests_run;
    int tests_failed;
    int cyc;

    // Reference model: memory image plus per-cycle history of what each cycle presented.
    logic [31:0] model_mem [Depth];
    bit          hist_acc   [MaxCyc];
    bit          hist_fault [MaxCyc];
    logic [31:0] hist_data  [MaxCyc];
    bit          hist_flush [MaxCyc];
    bit          hist_reset [MaxCyc];
    logic [31:0] model_cnt;

    function automatic bit in_rng(input logic [29:0] a);
        longint ua;
        ua = longint'(a);
        return (ua >= BaseW) && (ua < BaseW + Depth);
    endfunction

    function automatic logic [29:0] waddr(input int offset);
        return 30'(BaseW + offset);
    endfunction

    // A response is visible L cycles after accept unless a reset in [n, t-1] or a flush in
    // [n+1, t-1] intervened.
    function automatic logic [33:0] expected(input int t, input int lat);
        int n;
        bit v;
        if (t < lat) return '0;
        n = t - lat;
        v = hist_acc[n];
        for (int r = n; r < t; r++) if (hist_reset[r]) v = 1'b0;
        for (int f = n + 1; f < t; f++) if (hist_flush[f]) v = 1'b0;
        if (!v) return '0;
        return {1'b1, hist_fault[n], hist_data[n]};
    endfunction

    task automatic check(input string tag, input int dut, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s lat=%0d cyc=%0d observed=%h expected=%h", tag, dut + 1, cyc, obs, exp);
        end
    endtask

    task automatic step(input logic fv, input logic [29:0] fa, input logic fl, input logic le,
                        input logic [29:0] la, input logic [31:0] ld, input logic rst);
        bit acc;
        logic [33:0] e;
        fetch_valid = fv;
        fetch_addr  = fa;
        flush       = fl;
        load_enable = le;
        load_addr   = la;
        load_data   = ld;
        reset       = rst;
        #1;
        for (int g = 0; g < NumDut; g++) check("fetch_ready", g, 32'(ready[g]), 32'(!le));
        if (cyc >= MaxCyc - 1) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MaxCyc - 1);
            tests_failed++;
            $fatal(1, "cycle budget exhausted");
        end
        acc = fv && !le;
        hist_acc[cyc]   = acc;
        hist_fault[cyc] = acc && !in_rng(fa);
        hist_data[cyc]  = (acc && in_rng(fa)) ? model_mem[int'(longint'(fa) - BaseW)] : '0;
        hist_flush[cyc] = fl;
        hist_reset[cyc] = rst;
        if (le && in_rng(la)) model_mem[int'(longint'(la) - BaseW)] = ld;
        if (rst) model_cnt = '0;
        else if (acc) model_cnt = model_cnt + 32'd1;
        @(posedge clock);
        cyc++;
        #1;
        for (int g = 0; g < NumDut; g++) begin
            e = expected(cyc, g + 1);
            check("inst_valid", g, 32'(ivalid[g]), 32'(e[33]));
            check("inst_fault", g, 32'(ifault[g]), 32'(e[32]));
            check("inst_data", g, idata[g], e[31:0]);
`ifdef INSTRUCTION_MEMORY_FETCH_COUNT_EN
            check("fetch_count", g, cnt[g], model_cnt);
`endif
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic fetch(input logic [29:0] a, input logic fl);
        step(1'b1, a, fl, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic load(input logic [29:0] a, input logic [31:0] d);
        step(1'b0, '0, 1'b0, 1'b1, a, d, 1'b0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        model_cnt    = '0;
        for (int i = 0; i < MaxCyc; i++) begin
            hist_acc[i]   = 1'b0;
            hist_fault[i] = 1'b0;
            hist_data[i]  = '0;
            hist_flush[i] = 1'b0;
            hist_reset[i] = 1'b0;
        end

        // Reset, then fill the whole memory so every in-range read is defined.
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
        for (int i = 0; i < Depth; i++) load(waddr(i), $urandom);

        // Load and read back-to-back.
        load(30'(32'h3000 >> 2), 32'h1111_1111);
        load(30'(32'h3004 >> 2), 32'h2222_2222);
        fetch(30'(32'h3000 >> 2), 1'b0);
        fetch(30'(32'h3004 >> 2), 1'b0);
        idle(3);

        // Range faults just outside both ends, plus far-out addresses.
        fetch(30'(32'h2FFC >> 2), 1'b0);
        fetch(30'((32'h3000 + 4 * Depth) >> 2), 1'b0);
        fetch(30'h0000_0000, 1'b0);
        fetch(30'h3FFF_FFFF, 1'b0);
        fetch(waddr(Depth - 1), 1'b0);
        idle(3);

        // Load priority: stalled fetch sees the freshly loaded word.
        step(1'b1, waddr(5), 1'b0, 1'b1, waddr(5), 32'hCAFE_0005, 1'b0);
        step(1'b1, waddr(5), 1'b0, 1'b1, waddr(5), 32'hBEEF_0005, 1'b0);
        fetch(waddr(5), 1'b0);
        idle(3);

        // Out-of-range loads whose wrapped index aliases word 0 must be dropped.
        load(waddr(Depth), 32'hDEAD_0001);
        load(30'(BaseW - Depth), 32'hDEAD_0002);
        fetch(waddr(0), 1'b0);
        idle(3);

        // Flush alongside the new target fetch.
        fetch(waddr(2), 1'b0);
        fetch(waddr(3), 1'b0);
        fetch(waddr(4), 1'b0);
        fetch(waddr(7), 1'b1);
        idle(4);

        // Reset mid-flight, with a load landing during reset.
        fetch(waddr(8), 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, waddr(9), 32'h0BAD_F00D, 1'b1);
        idle(3);
        fetch(waddr(9), 1'b0);
        fetch(waddr(1), 1'b0);
        idle(3);

        // Randomized traffic around the address window edges.
        for (int i = 0; i < 300; i++) begin
            logic fv, fl, le, rst;
            logic [29:0] fa, la;
            fv  = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 9) == 0);
            le  = ($urandom_range(0, 4) == 0);
            rst = ($urandom_range(0, 39) == 0);
            fa  = 30'(BaseW - 2 + $urandom_range(0, Depth + 3));
            la  = 30'(BaseW - 2 + $urandom_range(0, Depth + 3));
            step(fv, fa, fl, le, la, $urandom, rst);
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
